// File: rtl/pulse_freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_freq_meter_pkg
//   Shared definitions for the gated pulse frequency meter:
//     state_t          - measurement FSM states (IDLE, COUNT)
//     GATE_CYCLES_DEF  - default gate window length in clocks (1 s at 100 MHz)
//     CNT_W_DEF        - default pulse counter / result width
//     gate_width()     - width of the gate counter for a given window length
// -----------------------------------------------------------------------------
package pulse_freq_meter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int unsigned GATE_CYCLES_DEF = 100_000_000;
  localparam int unsigned CNT_W_DEF       = 32;

  // $clog2 of the window length, floored at 1 so the counter always exists.
  function automatic int unsigned gate_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pulse_freq_meter_gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
//   Free-running gate window counter for pulse_freq_meter. Counts
//   0..GATE_CYCLES-1 while run is high and wraps straight back to 0 so that
//   consecutive windows abut with no dead cycle. Dropping run clears the
//   count, so the next window always starts at gate_cnt = 0.
//
//   Parameters:
//     GATE_CYCLES - window length in clocks (2 or more)
//   Ports:
//     CLK   in  system clock
//     RST_n in  asynchronous active-low reset
//     run   in  window is active this cycle
//     last  out high on the final gate cycle while run is high
// -----------------------------------------------------------------------------
module gate_timer
  import pulse_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic run,
  output logic last
);

  localparam int unsigned       GATE_W   = gate_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0] LAST_CNT = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] gate_cnt;

  assign last = run && (gate_cnt == LAST_CNT);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      gate_cnt <= '0;
    end else if (!run || last) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
    end
  end

endmodule

// File: rtl/pulse_freq_meter.sv
// -----------------------------------------------------------------------------
// pulse_freq_meter
//   Gated frequency meter. Counts one-cycle pulses from the debounce filter
//   over a fixed window of GATE_CYCLES clocks, then latches the total into
//   oCount and strobes oValid for one cycle. Windows run back to back while
//   iEnable stays high; dropping iEnable discards the partial window.
//
//   Build option:
//     PULSE_FREQ_METER_OVF_EN - when defined, the pulse counter saturates at
//       all-ones and oOverflow reports a saturated window. When undefined the
//       counter wraps and oOverflow is tied low.
//
//   Parameters:
//     GATE_CYCLES - window length in clocks (2 or more)
//     CNT_W       - pulse counter and oCount width
//   Ports:
//     CLK       in  system clock
//     RST_n     in  asynchronous active-low reset
//     iPulse    in  one-cycle pulse per debounced rising edge
//     iEnable   in  level-sensitive measurement enable
//     oCount    out pulse count of the last completed window
//     oValid    out one-cycle strobe, oCount just updated
//     oOverflow out last completed window saturated the counter
// -----------------------------------------------------------------------------
module pulse_freq_meter
  import pulse_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             iPulse,
  input  logic             iEnable,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oOverflow
);

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic             last;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] pulse_sum;

  // ---------------------------------------------------------------------------
  // FSM: run is only asserted in COUNT with iEnable still high, so an enable
  // drop on any cycle (including the last one) discards the window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      IDLE: begin
        if (iEnable) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (iEnable) begin
          run = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .CLK  (CLK),
    .RST_n(RST_n),
    .run  (run),
    .last (last)
  );

  // ---------------------------------------------------------------------------
  // Pulse accumulation. pulse_sum already includes this cycle's pulse, which
  // is what gets latched on the last gate cycle so a boundary pulse is kept.
  // ---------------------------------------------------------------------------
`ifdef PULSE_FREQ_METER_OVF_EN
  logic sticky_ovf;
  logic sat_hit;

  assign sat_hit = iPulse && (pulse_cnt == '1);

  always_comb begin
    pulse_sum = pulse_cnt + CNT_W'(iPulse);
    if (sat_hit) begin
      pulse_sum = '1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sticky_ovf <= 1'b0;
    end else if (!run || last) begin
      sticky_ovf <= 1'b0;
    end else if (sat_hit) begin
      sticky_ovf <= 1'b1;
    end
  end

  // Saturation on the final cycle itself must still be reported.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      oOverflow <= 1'b0;
    end else if (last) begin
      oOverflow <= sticky_ovf || sat_hit;
    end
  end
`else
  assign pulse_sum = pulse_cnt + CNT_W'(iPulse);
  assign oOverflow = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pulse_cnt <= '0;
    end else if (!run || last) begin
      pulse_cnt <= '0;
    end else begin
      pulse_cnt <= pulse_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      oCount <= '0;
      oValid <= 1'b0;
    end else begin
      oValid <= last;
      if (last) begin
        oCount <= pulse_sum;
      end
    end
  end

endmodule

// File: tb/tb_pulse_freq_meter.sv
module tb_pulse_freq_meter;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       iPulse;
  logic       iEnable;
  logic [3:0] count_a;
  logic       valid_a;
  logic       ovf_a;
  logic [2:0] count_b;
  logic       valid_b;
  logic       ovf_b;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] last_cnt;

`ifdef PULSE_FREQ_METER_OVF_EN
  localparam logic [31:0] EXP_B_CNT = 32'd7;
  localparam logic [31:0] EXP_B_OVF = 32'd1;
`else
  localparam logic [31:0] EXP_B_CNT = 32'd2;
  localparam logic [31:0] EXP_B_OVF = 32'd0;
`endif

  always #5 CLK = ~CLK;

  pulse_freq_meter #(
    .GATE_CYCLES(10),
    .CNT_W      (4)
  ) u_dut_a (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .iPulse   (iPulse),
    .iEnable  (iEnable),
    .oCount   (count_a),
    .oValid   (valid_a),
    .oOverflow(ovf_a)
  );

  pulse_freq_meter #(
    .GATE_CYCLES(10),
    .CNT_W      (3)
  ) u_dut_b (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .iPulse   (iPulse),
    .iEnable  (iEnable),
    .oCount   (count_b),
    .oValid   (valid_b),
    .oOverflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller leaves the bench at the negedge of gate cycle 0. Bit g of mask is
  // the pulse for gate cycle g; oValid must appear only after gate cycle 9.
  task automatic run_window(input string tag, input logic [9:0] mask, input logic [31:0] exp_cnt);
    for (int g = 0; g < 10; g++) begin
      iPulse = mask[g];
      @(negedge CLK);
      chk({tag, "_valid"}, 32'(valid_a), 32'(g == 9));
      if (g < 9) chk({tag, "_hold"}, 32'(count_a), last_cnt);
    end
    iPulse = 1'b0;
    chk({tag, "_count"}, 32'(count_a), exp_cnt);
    chk({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    last_cnt = exp_cnt;
  endtask

  initial begin
    RST_n    = 1'b0;
    iEnable  = 1'b0;
    iPulse   = 1'b0;
    last_cnt = '0;
    repeat (3) @(negedge CLK);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);

    RST_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      iPulse = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("idle_valid", 32'(valid_a), 32'd0);
    end
    chk("idle_count", 32'(count_a), 32'd0);
    chk("idle_ovf",   32'(ovf_a),   32'd0);

    // IDLE exit cycle: this pulse must not be counted
    iEnable = 1'b1;
    iPulse  = 1'b1;
    @(negedge CLK);
    run_window("w_256",    10'b0001100100, 32'd3);
    run_window("w_quiet",  10'b0000000000, 32'd0);
    run_window("w_edge09", 10'b1000000001, 32'd2);
    run_window("w_edge0",  10'b0000000001, 32'd1);

    // Every cycle pulsed: 10 pulses overrun the 3-bit instance
    for (int g = 0; g < 10; g++) begin
      iPulse = 1'b1;
      @(negedge CLK);
      chk("ovf_valid_a", 32'(valid_a), 32'(g == 9));
      chk("ovf_valid_b", 32'(valid_b), 32'(g == 9));
    end
    iPulse = 1'b0;
    chk("ovf_count_a", 32'(count_a), 32'd10);
    chk("ovf_flag_a",  32'(ovf_a),   32'd0);
    chk("ovf_count_b", 32'(count_b), EXP_B_CNT);
    chk("ovf_flag_b",  32'(ovf_b),   EXP_B_OVF);
    last_cnt = 32'd10;
    run_window("w_after_ovf", 10'b0000000000, 32'd0);
    chk("post_ovf_count_b", 32'(count_b), 32'd0);
    chk("post_ovf_flag_b",  32'(ovf_b),   32'd0);

    // Abort: 4 pulses, then enable drops on gate cycle 6
    run_window("w_pre_abort", 10'b0100001010, 32'd3);
    for (int g = 0; g < 6; g++) begin
      iPulse = (g < 4);
      @(negedge CLK);
      chk("abort_run_valid", 32'(valid_a), 32'd0);
    end
    iEnable = 1'b0;
    iPulse  = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 14; i++) begin
      iPulse = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("abort_valid", 32'(valid_a), 32'd0);
    end
    chk("abort_count", 32'(count_a), 32'd3);

    iEnable = 1'b1;
    iPulse  = 1'b0;
    @(negedge CLK);
    run_window("w_reenable", 10'b0000010000, 32'd1);

    // Asynchronous reset right after the closing edge of a window
    for (int g = 0; g < 9; g++) begin
      iPulse = (g == 3);
      @(negedge CLK);
      chk("pre_rst_valid", 32'(valid_a), 32'd0);
    end
    iPulse = 1'b1;
    @(posedge CLK);
    #2;
    chk("pre_rst_strobe", 32'(valid_a), 32'd1);
    chk("pre_rst_count",  32'(count_a), 32'd2);
    RST_n = 1'b0;
    #1;
    chk("arst_count", 32'(count_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    chk("arst_ovf",   32'(ovf_a),   32'd0);
    @(negedge CLK);
    RST_n    = 1'b1;
    iEnable  = 1'b0;
    last_cnt = '0;
    for (int i = 0; i < 12; i++) begin
      iPulse = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("post_rst_valid", 32'(valid_a), 32'd0);
    end
    chk("post_rst_count", 32'(count_a), 32'd0);

    iEnable = 1'b1;
    iPulse  = 1'b0;
    @(negedge CLK);
    run_window("w_post_rst", 10'b0000100110, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
